// File: rtl/otter_lsu_pkg.sv
// ---------------------------------------------------------------------------
// otter_lsu_pkg
// Shared types and constants for the OTTER load/store unit.
//   lsuState_t      : FSM states of the LSU sequencer
//   SZ_*            : func3[1:0] access-size encodings
//   IO_BASE_DEFAULT : first MMIO address (MMIO accesses are never split)
//   sizeBytes()     : number of bytes touched by a given access size
// ---------------------------------------------------------------------------
package otter_lsu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD0,
      ST_RD1,
      ST_RDL,
      ST_WR,
      ST_RESP
   } lsuState_t;

   localparam logic [1:0] SZ_BYTE    = 2'd0;
   localparam logic [1:0] SZ_HALF    = 2'd1;
   localparam logic [1:0] SZ_WORD    = 2'd2;
   localparam logic [1:0] SZ_ILLEGAL = 2'd3;

   localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

   // Byte count of an access; the illegal size never reaches memory, so it
   // simply maps to a full word here.
   function automatic logic [2:0] sizeBytes(input logic [1:0] size);
      logic [2:0] n;
      case (size)
         SZ_BYTE: n = 3'd1;
         SZ_HALF: n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/otter_lsu_extract.sv
// ---------------------------------------------------------------------------
// otter_lsu_extract
// Combinational load-data alignment. The two words covering a (possibly
// word-crossing) load are concatenated, shifted down by the byte offset and
// the low 1/2/4 bytes are kept, sign- or zero-extended.
//   i_wLo    : word at the aligned load address
//   i_wHi    : following word (only meaningful for split loads)
//   i_off    : byte offset of the load within i_wLo
//   i_size   : access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   i_uns    : 1 = zero-extend, 0 = sign-extend
//   o_result : extended load result
// ---------------------------------------------------------------------------
module otter_lsu_extract
   import otter_lsu_pkg::*;
(
   input  logic [31:0] i_wLo,
   input  logic [31:0] i_wHi,
   input  logic [1:0]  i_off,
   input  logic [1:0]  i_size,
   input  logic        i_uns,
   output logic [31:0] o_result
);

   logic [63:0] w_pair;
   logic [31:0] w_shifted;

   // Shift the word pair down by the byte offset, then trim and extend to the
   // requested size. The offset is at most 3 bytes, so the 32-bit window always
   // lies inside the 64-bit pair.
   always_comb begin
      w_pair    = {i_wHi, i_wLo};
      w_shifted = w_pair[{i_off, 3'b000} +: 32];
      case (i_size)
         SZ_BYTE: o_result = {{24{w_shifted[7] & ~i_uns}}, w_shifted[7:0]};
         SZ_HALF: o_result = {{16{w_shifted[15] & ~i_uns}}, w_shifted[15:0]};
         default: o_result = w_shifted;
      endcase
   end

endmodule

// File: rtl/otter_lsu.sv
// ---------------------------------------------------------------------------
// otter_lsu
// Load/store unit between the OTTER MEM stage and memory data port 2.
// Accepts one request at a time, splits word-crossing memory accesses (two
// aligned reads merged locally, or a run of byte writes), passes MMIO
// accesses through untouched, and returns exactly one response per request.
// Ports:
//   CLK, RST_N          : clock (rising edge), async active-low reset
//   REQ_VALID/REQ_READY : request handshake (READY only while idle)
//   REQ_WE/ADDR/WDATA/SIZE/UNS : request fields (func3 split into SIZE/UNS)
//   RSP_VALID           : one-cycle response pulse
//   RSP_RDATA/SPLIT/ERR : registered response fields, held until next response
//   MEM_ADDR2/DIN2/WRITE2/READ2/SIZE/SIGN : registered memory port outputs
//   MEM_DOUT2           : memory read data, valid the cycle after MEM_READ2
// ---------------------------------------------------------------------------
module otter_lsu
   import otter_lsu_pkg::*;
#(
   parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
)(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_WE,
   input  logic [31:0] REQ_ADDR,
   input  logic [31:0] REQ_WDATA,
   input  logic [1:0]  REQ_SIZE,
   input  logic        REQ_UNS,
   output logic        RSP_VALID,
   output logic [31:0] RSP_RDATA,
   output logic        RSP_SPLIT,
   output logic        RSP_ERR,
   output logic [31:0] MEM_ADDR2,
   output logic [31:0] MEM_DIN2,
   output logic        MEM_WRITE2,
   output logic        MEM_READ2,
   output logic [1:0]  MEM_SIZE,
   output logic        MEM_SIGN,
   input  logic [31:0] MEM_DOUT2
);

   lsuState_t   r_state, w_nextState;

   logic [31:0] r_addr, r_wdata, r_w0;
   logic [1:0]  r_size, r_cnt;
   logic        r_uns, r_cross, r_io;

   logic [31:0] r_memAddr, r_memDin;
   logic        r_memWrite, r_memRead, r_memSign;
   logic [1:0]  r_memSize;

   logic [31:0] w_memAddr, w_memDin;
   logic        w_memWrite, w_memRead, w_memSign;
   logic [1:0]  w_memSize, w_cnt;

   logic [31:0] r_rspRdata;
   logic        r_rspSplit, r_rspErr;

   logic        w_accept, w_reqCross, w_reqIo, w_split;
   logic [1:0]  w_lastIdx, w_nextIdx;
   logic [31:0] w_wLo, w_loadData, w_alignedAddr;

   assign w_accept      = REQ_VALID && (r_state == ST_IDLE);
   assign w_reqCross    = ({2'b00, REQ_ADDR[1:0]} + {1'b0, sizeBytes(REQ_SIZE)}) > 4'd4;
   assign w_reqIo       = REQ_ADDR >= IO_BASE;
   assign w_split       = r_cross && !r_io;
   assign w_lastIdx     = 2'(sizeBytes(r_size) - 3'd1);
   assign w_nextIdx     = r_cnt + 2'd1;
   assign w_alignedAddr = {r_addr[31:2], 2'b00};
   // For an unsplit load the only word is the one arriving now; for a split
   // load the first word was parked in r_w0 and the second is arriving now.
   assign w_wLo         = w_split ? r_w0 : MEM_DOUT2;

   otter_lsu_extract u_extract (
      .i_wLo    (w_wLo),
      .i_wHi    (MEM_DOUT2),
      .i_off    (r_addr[1:0]),
      .i_size   (r_size),
      .i_uns    (r_uns),
      .o_result (w_loadData)
   );

   // State register; reset drops straight back to idle, abandoning any split.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= ST_IDLE;
      else        r_state <= w_nextState;
   end

   // Next-state logic also decides what the memory port registers will hold
   // in the coming cycle, so the port is always driven from flops even on the
   // first access straight after accept.
   always_comb begin
      w_nextState = r_state;
      w_memRead   = 1'b0;
      w_memWrite  = 1'b0;
      w_memAddr   = r_memAddr;
      w_memDin    = r_memDin;
      w_memSize   = r_memSize;
      w_memSign   = r_memSign;
      w_cnt       = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (REQ_SIZE == SZ_ILLEGAL) begin
                  w_nextState = ST_RESP;
               end else if (!REQ_WE) begin
                  w_nextState = ST_RD0;
                  w_memRead   = 1'b1;
                  w_memAddr   = w_reqIo ? REQ_ADDR : {REQ_ADDR[31:2], 2'b00};
                  w_memSize   = w_reqIo ? REQ_SIZE : SZ_WORD;
                  w_memSign   = w_reqIo ? REQ_UNS : 1'b0;
               end else begin
                  w_nextState = ST_WR;
                  w_memWrite  = 1'b1;
                  w_memAddr   = REQ_ADDR;
                  w_cnt       = 2'd0;
                  if (w_reqCross && !w_reqIo) begin
                     w_memSize = SZ_BYTE;
                     w_memDin  = {24'b0, REQ_WDATA[7:0]};
                  end else begin
                     w_memSize = REQ_SIZE;
                     w_memDin  = REQ_WDATA;
                  end
               end
            end
         end
         ST_RD0: begin
            if (w_split) begin
               w_nextState = ST_RD1;
               w_memRead   = 1'b1;
               w_memAddr   = w_alignedAddr + 32'd4;
            end else begin
               w_nextState = ST_RDL;
            end
         end
         ST_RD1:  w_nextState = ST_RDL;
         ST_RDL:  w_nextState = ST_RESP;
         ST_WR: begin
            // r_cnt is the index of the byte on the bus this cycle.
            if (w_split && (r_cnt != w_lastIdx)) begin
               w_memWrite = 1'b1;
               w_memAddr  = r_addr + {30'b0, w_nextIdx};
               w_memDin   = {24'b0, r_wdata[{w_nextIdx, 3'b000} +: 8]};
               w_cnt      = w_nextIdx;
            end else begin
               w_nextState = ST_RESP;
            end
         end
         ST_RESP: w_nextState = ST_IDLE;
         default: w_nextState = ST_IDLE;
      endcase
   end

   // Memory port registers; the async reset makes the strobes fall at once.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_memAddr  <= '0;
         r_memDin   <= '0;
         r_memWrite <= 1'b0;
         r_memRead  <= 1'b0;
         r_memSize  <= '0;
         r_memSign  <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_memAddr  <= w_memAddr;
         r_memDin   <= w_memDin;
         r_memWrite <= w_memWrite;
         r_memRead  <= w_memRead;
         r_memSize  <= w_memSize;
         r_memSign  <= w_memSign;
         r_cnt      <= w_cnt;
      end
   end

   // Request capture, split-load first word, and the held response fields.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_addr     <= '0;
         r_wdata    <= '0;
         r_size     <= '0;
         r_uns      <= 1'b0;
         r_cross    <= 1'b0;
         r_io       <= 1'b0;
         r_w0       <= '0;
         r_rspRdata <= '0;
         r_rspSplit <= 1'b0;
         r_rspErr   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr  <= REQ_ADDR;
            r_wdata <= REQ_WDATA;
            r_size  <= REQ_SIZE;
            r_uns   <= REQ_UNS;
            r_cross <= w_reqCross;
            r_io    <= w_reqIo;
         end
         if (r_state == ST_RD1) r_w0 <= MEM_DOUT2;
         case (r_state)
            ST_IDLE: begin
               if (w_accept && (REQ_SIZE == SZ_ILLEGAL)) begin
                  r_rspRdata <= '0;
                  r_rspSplit <= 1'b0;
                  r_rspErr   <= 1'b1;
               end
            end
            ST_RDL: begin
               r_rspRdata <= r_io ? MEM_DOUT2 : w_loadData;
               r_rspSplit <= w_split;
               r_rspErr   <= 1'b0;
            end
            ST_WR: begin
               if (w_nextState == ST_RESP) begin
                  r_rspRdata <= '0;
                  r_rspSplit <= w_split;
                  r_rspErr   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign REQ_READY  = (r_state == ST_IDLE);
   assign RSP_VALID  = (r_state == ST_RESP);
   assign RSP_RDATA  = r_rspRdata;
   assign RSP_SPLIT  = r_rspSplit;
   assign RSP_ERR    = r_rspErr;
   assign MEM_ADDR2  = r_memAddr;
   assign MEM_DIN2   = r_memDin;
   assign MEM_WRITE2 = r_memWrite;
   assign MEM_READ2  = r_memRead;
   assign MEM_SIZE   = r_memSize;
   assign MEM_SIGN   = r_memSign;

endmodule

// File: tb/tb_otter_lsu.sv
// ---------------------------------------------------------------------------
// tb_otter_lsu
// Directed testbench for otter_lsu. A byte-addressable memory model answers
// port 2 (read data the cycle after MEM_READ2) and logs every memory command
// so each scenario can check the exact access sequence it caused.
// ---------------------------------------------------------------------------
module tb_otter_lsu;

   localparam logic [31:0] IO_BASE = 32'h1100_0000;
   localparam logic [31:0] IO_IN   = 32'h1234_5678;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] din;
      logic [1:0]  size;
      logic        sign;
   } memOp_t;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        REQ_VALID, REQ_READY, REQ_WE, REQ_UNS;
   logic [31:0] REQ_ADDR, REQ_WDATA;
   logic [1:0]  REQ_SIZE;
   logic        RSP_VALID, RSP_SPLIT, RSP_ERR;
   logic [31:0] RSP_RDATA;
   logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
   logic        MEM_WRITE2, MEM_READ2, MEM_SIGN;
   logic [1:0]  MEM_SIZE;

   int checks   = 0;
   int failures = 0;

   bit [7:0]    mem [bit [31:0]];
   memOp_t      opLog[$];
   logic [31:0] rdPending;
   bit          rdPendingValid = 1'b0;

   otter_lsu #(.IO_BASE(IO_BASE)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
      .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_SIZE(REQ_SIZE), .REQ_UNS(REQ_UNS),
      .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_SPLIT(RSP_SPLIT), .RSP_ERR(RSP_ERR),
      .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_WRITE2(MEM_WRITE2),
      .MEM_READ2(MEM_READ2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .MEM_DOUT2(MEM_DOUT2)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] rdByte(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 8'h00;
   endfunction

   function automatic memOp_t opAt(input int i);
      if (i < opLog.size()) return opLog[i];
      return '1;
   endfunction

   task automatic setWord(input logic [31:0] a, input logic [31:0] d);
      for (int b = 0; b < 4; b++) mem[a + b] = d[8*b +: 8];
   endtask

   // Memory model: commands are sampled mid-cycle, writes land immediately,
   // and read data is presented from the next rising edge.
   always @(negedge CLK) begin
      rdPendingValid = 1'b0;
      if (MEM_READ2 === 1'b1) begin
         opLog.push_back('{1'b0, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN});
         rdPendingValid = 1'b1;
         if (MEM_ADDR2 >= IO_BASE) rdPending = IO_IN;
         else rdPending = {rdByte({MEM_ADDR2[31:2], 2'b11}), rdByte({MEM_ADDR2[31:2], 2'b10}),
                           rdByte({MEM_ADDR2[31:2], 2'b01}), rdByte({MEM_ADDR2[31:2], 2'b00})};
      end
      if (MEM_WRITE2 === 1'b1) begin
         opLog.push_back('{1'b1, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN});
         if (MEM_ADDR2 < IO_BASE)
            for (int b = 0; b < (1 << MEM_SIZE); b++) mem[MEM_ADDR2 + b] = MEM_DIN2[8*b +: 8];
      end
   end

   always @(posedge CLK) if (rdPendingValid) MEM_DOUT2 <= rdPending;

   // Issue one request and wait (bounded) for its response. lat is the number
   // of rising edges after the accept edge at which RSP_VALID is seen; -1 on timeout.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic uns, output int lat,
                                output logic [31:0] rdata, output logic split, output logic err);
      lat = -1; rdata = 'x; split = 'x; err = 'x;
      @(negedge CLK);
      opLog.delete();
      REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = addr; REQ_WDATA = wdata;
      REQ_SIZE = size; REQ_UNS = uns;
      @(posedge CLK);
      #1 REQ_VALID = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge CLK);
         if (RSP_VALID === 1'b1) begin
            lat = k; rdata = RSP_RDATA; split = RSP_SPLIT; err = RSP_ERR;
            break;
         end
      end
   endtask

   int          lat;
   logic [31:0] rdata;
   logic        split, err;
   memOp_t      op;

   task automatic test_reset();
      checks++; if (REQ_READY !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", REQ_READY); end
      checks++; if (RSP_VALID !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", RSP_VALID); end
      checks++; if ({MEM_READ2, MEM_WRITE2} !== 2'b00) begin failures++; $display("[TB] FAIL reset_strobes got=%b exp=00", {MEM_READ2, MEM_WRITE2}); end
      checks++; if (MEM_ADDR2 !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr got=%h exp=0", MEM_ADDR2); end
      checks++; if ({RSP_RDATA, RSP_SPLIT, RSP_ERR} !== 34'h0) begin failures++; $display("[TB] FAIL reset_rsp got=%h exp=0", {RSP_RDATA, RSP_SPLIT, RSP_ERR}); end
   endtask

   task automatic test_aligned_load();
      setWord(32'h100, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, lat, rdata, split, err);
      checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL lw_latency got=%0d exp=3", lat); end
      checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL lw_rdata got=%h exp=deadbeef", rdata); end
      checks++; if ({split, err} !== 2'b00) begin failures++; $display("[TB] FAIL lw_flags got=%b exp=00", {split, err}); end
      checks++; if (opLog.size() !== 1) begin failures++; $display("[TB] FAIL lw_nops got=%0d exp=1", opLog.size()); end
      op = opAt(0);
      checks++; if ({op.we, op.addr, op.size} !== {1'b0, 32'h100, 2'd2}) begin failures++; $display("[TB] FAIL lw_op got=%b/%h/%0d exp=0/100/2", op.we, op.addr, op.size); end
      @(negedge CLK);
      checks++; if (RSP_VALID !== 1'b0) begin failures++; $display("[TB] FAIL lw_pulse got=%b exp=0", RSP_VALID); end
      checks++; if (RSP_RDATA !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL lw_hold got=%h exp=deadbeef", RSP_RDATA); end
   endtask

   task automatic test_narrow_loads();
      logic [31:0] aT [6] = '{32'h101, 32'h101, 32'h102, 32'h102, 32'h100, 32'h103};
      logic [1:0]  sT [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
      logic        uT [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] eT [6] = '{32'hFFFF_FFBE, 32'h0000_00BE, 32'hFFFF_DEAD, 32'h0000_DEAD,
                              32'hFFFF_BEEF, 32'hFFFF_FFDE};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, aT[i], 32'h0, sT[i], uT[i], lat, rdata, split, err);
         checks++; if (rdata !== eT[i] || lat !== 3 || split !== 1'b0) begin failures++;
            $display("[TB] FAIL narrow_load[%0d] got=%h lat=%0d split=%b exp=%h lat=3 split=0", i, rdata, lat, split, eT[i]); end
      end
   endtask

   task automatic test_split_load();
      setWord(32'h100, 32'h8011_2233);
      setWord(32'h104, 32'h4455_66FF);
      applyStimulus(1'b0, 32'h103, 32'h0, 2'd1, 1'b0, lat, rdata, split, err);
      checks++; if (lat !== 4) begin failures++; $display("[TB] FAIL lh_split_latency got=%0d exp=4", lat); end
      checks++; if (rdata !== 32'hFFFF_FF80) begin failures++; $display("[TB] FAIL lh_split_rdata got=%h exp=ffffff80", rdata); end
      checks++; if (split !== 1'b1) begin failures++; $display("[TB] FAIL lh_split_flag got=%b exp=1", split); end
      checks++; if (opLog.size() !== 2 || opAt(0).addr !== 32'h100 || opAt(1).addr !== 32'h104) begin failures++;
         $display("[TB] FAIL lh_split_reads got=%0d ops %h,%h exp=2 ops 100,104", opLog.size(), opAt(0).addr, opAt(1).addr); end
      applyStimulus(1'b0, 32'h103, 32'h0, 2'd1, 1'b1, lat, rdata, split, err);
      checks++; if (rdata !== 32'h0000_FF80) begin failures++; $display("[TB] FAIL lhu_split_rdata got=%h exp=0000ff80", rdata); end
      applyStimulus(1'b0, 32'h102, 32'h0, 2'd2, 1'b0, lat, rdata, split, err);
      checks++; if (rdata !== 32'h66FF_8011 || lat !== 4) begin failures++; $display("[TB] FAIL lw_split_rdata got=%h lat=%0d exp=66ff8011 lat=4", rdata, lat); end
   endtask

   task automatic test_split_store();
      logic [31:0] aT [4] = '{32'h202, 32'h203, 32'h204, 32'h205};
      logic [31:0] dT [4] = '{32'hDD, 32'hCC, 32'hBB, 32'hAA};
      applyStimulus(1'b1, 32'h202, 32'hAABB_CCDD, 2'd2, 1'b0, lat, rdata, split, err);
      checks++; if (lat !== 5) begin failures++; $display("[TB] FAIL sw_split_latency got=%0d exp=5", lat); end
      checks++; if ({rdata, split, err} !== {32'h0, 1'b1, 1'b0}) begin failures++; $display("[TB] FAIL sw_split_rsp got=%h/%b/%b exp=0/1/0", rdata, split, err); end
      checks++; if (opLog.size() !== 4) begin failures++; $display("[TB] FAIL sw_split_nops got=%0d exp=4", opLog.size()); end
      for (int i = 0; i < 4; i++) begin
         op = opAt(i);
         checks++; if ({op.we, op.addr, op.din, op.size} !== {1'b1, aT[i], dT[i], 2'd0}) begin failures++;
            $display("[TB] FAIL sw_split_byte[%0d] got=%b/%h/%h/%0d exp=1/%h/%h/0", i, op.we, op.addr, op.din, op.size, aT[i], dT[i]); end
      end
      applyStimulus(1'b0, 32'h200, 32'h0, 2'd2, 1'b0, lat, rdata, split, err);
      checks++; if (rdata !== 32'hCCDD_0000) begin failures++; $display("[TB] FAIL sw_split_readback_lo got=%h exp=ccdd0000", rdata); end
      applyStimulus(1'b0, 32'h204, 32'h0, 2'd2, 1'b0, lat, rdata, split, err);
      checks++; if (rdata !== 32'h0000_AABB) begin failures++; $display("[TB] FAIL sw_split_readback_hi got=%h exp=0000aabb", rdata); end
      applyStimulus(1'b1, 32'h2FF, 32'h0000_1234, 2'd1, 1'b0, lat, rdata, split, err);
      checks++; if (lat !== 3 || opLog.size() !== 2 || opAt(0).din !== 32'h34 || opAt(1).addr !== 32'h300 || opAt(1).din !== 32'h12) begin failures++;
         $display("[TB] FAIL sh_split got lat=%0d n=%0d d0=%h a1=%h d1=%h exp lat=3 n=2 d0=34 a1=300 d1=12", lat, opLog.size(), opAt(0).din, opAt(1).addr, opAt(1).din); end
   endtask

   task automatic test_unsplit_store();
      applyStimulus(1'b1, 32'h400, 32'hCAFE_F00D, 2'd2, 1'b0, lat, rdata, split, err);
      op = opAt(0);
      checks++; if (lat !== 2 || split !== 1'b0 || opLog.size() !== 1) begin failures++; $display("[TB] FAIL sw_aligned got lat=%0d split=%b n=%0d exp lat=2 split=0 n=1", lat, split, opLog.size()); end
      checks++; if ({op.addr, op.din, op.size} !== {32'h400, 32'hCAFE_F00D, 2'd2}) begin failures++; $display("[TB] FAIL sw_aligned_op got=%h/%h/%0d exp=400/cafef00d/2", op.addr, op.din, op.size); end
      applyStimulus(1'b1, 32'h402, 32'h0000_BEAD, 2'd1, 1'b0, lat, rdata, split, err);
      op = opAt(0);
      checks++; if (lat !== 2 || opLog.size() !== 1 || {op.addr, op.size} !== {32'h402, 2'd1}) begin failures++;
         $display("[TB] FAIL sh_edge got lat=%0d n=%0d addr=%h size=%0d exp lat=2 n=1 addr=402 size=1", lat, opLog.size(), op.addr, op.size); end
   endtask

   task automatic test_io();
      applyStimulus(1'b1, 32'h1100_0004, 32'h0000_005A, 2'd0, 1'b0, lat, rdata, split, err);
      op = opAt(0);
      checks++; if (lat !== 2 || split !== 1'b0 || opLog.size() !== 1) begin failures++; $display("[TB] FAIL io_sb got lat=%0d split=%b n=%0d exp lat=2 split=0 n=1", lat, split, opLog.size()); end
      checks++; if ({op.we, op.addr, op.din, op.size} !== {1'b1, 32'h1100_0004, 32'h5A, 2'd0}) begin failures++; $display("[TB] FAIL io_sb_op got=%b/%h/%h/%0d exp=1/11000004/5a/0", op.we, op.addr, op.din, op.size); end
      applyStimulus(1'b0, 32'h1100_0000, 32'h0, 2'd2, 1'b0, lat, rdata, split, err);
      checks++; if (rdata !== IO_IN || lat !== 3) begin failures++; $display("[TB] FAIL io_lw got=%h lat=%0d exp=12345678 lat=3", rdata, lat); end
      applyStimulus(1'b0, 32'h1100_0003, 32'h0, 2'd1, 1'b1, lat, rdata, split, err);
      op = opAt(0);
      checks++; if (rdata !== IO_IN || lat !== 3 || split !== 1'b0 || opLog.size() !== 1) begin failures++;
         $display("[TB] FAIL io_lhu got=%h lat=%0d split=%b n=%0d exp=12345678 lat=3 split=0 n=1", rdata, lat, split, opLog.size()); end
      checks++; if ({op.addr, op.size, op.sign} !== {32'h1100_0003, 2'd1, 1'b1}) begin failures++; $display("[TB] FAIL io_lhu_op got=%h/%0d/%b exp=11000003/1/1", op.addr, op.size, op.sign); end
   endtask

   task automatic test_error();
      applyStimulus(1'b0, 32'h100, 32'h0, 2'd3, 1'b0, lat, rdata, split, err);
      checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL err_latency got=%0d exp=1", lat); end
      checks++; if ({err, split, rdata} !== {1'b1, 1'b0, 32'h0}) begin failures++; $display("[TB] FAIL err_rsp got=%b/%b/%h exp=1/0/0", err, split, rdata); end
      checks++; if (opLog.size() !== 0) begin failures++; $display("[TB] FAIL err_load_mem_ops got=%0d exp=0", opLog.size()); end
      applyStimulus(1'b1, 32'h202, 32'hFFFF_FFFF, 2'd3, 1'b0, lat, rdata, split, err);
      checks++; if (opLog.size() !== 0 || err !== 1'b1) begin failures++; $display("[TB] FAIL err_store got n=%0d err=%b exp n=0 err=1", opLog.size(), err); end
   endtask

   task automatic test_back_to_back();
      setWord(32'h600, 32'h0BAD_F00D);
      applyStimulus(1'b0, 32'h600, 32'h0, 2'd3, 1'b0, lat, rdata, split, err);
      applyStimulus(1'b0, 32'h600, 32'h0, 2'd2, 1'b0, lat, rdata, split, err);
      checks++; if ({rdata, err} !== {32'h0BAD_F00D, 1'b0} || lat !== 3) begin failures++; $display("[TB] FAIL b2b_load got=%h err=%b lat=%0d exp=0badf00d err=0 lat=3", rdata, err, lat); end
   endtask

   task automatic test_reset_mid_split();
      bit sawRsp = 1'b0;
      @(negedge CLK);
      opLog.delete();
      REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 32'h503; REQ_WDATA = 32'h1122_3344;
      REQ_SIZE = 2'd2; REQ_UNS = 1'b0;
      @(posedge CLK);
      #1 REQ_VALID = 1'b0;
      checks++; if (REQ_READY !== 1'b0) begin failures++; $display("[TB] FAIL busy_ready got=%b exp=0", REQ_READY); end
      @(posedge CLK);
      #2;
      checks++; if ({MEM_WRITE2, MEM_ADDR2} !== {1'b1, 32'h504}) begin failures++; $display("[TB] FAIL mid_split_byte1 got=%b/%h exp=1/504", MEM_WRITE2, MEM_ADDR2); end
      RST_N = 1'b0;
      #1;
      checks++; if ({MEM_WRITE2, MEM_READ2} !== 2'b00) begin failures++; $display("[TB] FAIL async_strobe_drop got=%b exp=00", {MEM_WRITE2, MEM_READ2}); end
      repeat (3) begin @(negedge CLK); if (RSP_VALID !== 1'b0) sawRsp = 1'b1; end
      RST_N = 1'b1;
      repeat (4) begin @(negedge CLK); if (RSP_VALID !== 1'b0) sawRsp = 1'b1; end
      checks++; if (sawRsp !== 1'b0) begin failures++; $display("[TB] FAIL abandoned_rsp got=%b exp=0", sawRsp); end
      checks++; if (REQ_READY !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ready got=%b exp=1", REQ_READY); end
      checks++; if (opLog.size() !== 1 || opAt(0).addr !== 32'h503 || rdByte(32'h503) !== 8'h44 || rdByte(32'h504) !== 8'h00) begin failures++;
         $display("[TB] FAIL abandoned_writes got n=%0d a0=%h m503=%h m504=%h exp n=1 a0=503 m503=44 m504=00", opLog.size(), opAt(0).addr, rdByte(32'h503), rdByte(32'h504)); end
   endtask

   task automatic checkOutput();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
   endtask

   initial begin
      RST_N = 1'b0; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
      REQ_SIZE = '0; REQ_UNS = 1'b0;
      repeat (3) @(negedge CLK);
      test_reset();
      RST_N = 1'b1;
      test_aligned_load();
      test_narrow_loads();
      test_split_load();
      test_split_store();
      test_unsplit_store();
      test_io();
      test_error();
      test_back_to_back();
      test_reset_mid_split();
      checkOutput();
      $finish;
   end

endmodule
